// File: rtl/serial_add_seq.sv
// Bit-serial adder: one NOR-built full-adder slice reused for WIDTH cycles.
// Ports: clk, rst (async high), start/a/b/cin in; busy, done, sum, cout, ovf out.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.

module my_xor (
    input  logic a,
    input  logic b,
    output logic y
);
    logic t1, t2, t3, xn;
    assign t1 = ~(a | b);
    assign t2 = ~(a | t1);
    assign t3 = ~(b | t1);
    assign xn = ~(t2 | t3);
    assign y  = ~(xn | xn);
endmodule

module my_and (
    input  logic a,
    input  logic b,
    output logic y
);
    logic na, nb;
    assign na = ~(a | a);
    assign nb = ~(b | b);
    assign y  = ~(na | nb);
endmodule

module my_or (
    input  logic a,
    input  logic b,
    output logic y
);
    logic n;
    assign n = ~(a | b);
    assign y = ~(n | n);
endmodule

module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sr, b_sr;
    // Bit 0 of the partial sum would never be read again, so only the
    // upper WIDTH-1 bits are stored; the full word is formed in s_nxt.
    logic [WIDTH-2:0] s_sr;
    logic [WIDTH-1:0] s_nxt;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             last;

    logic s, co, p, g, pc, s_unused;

    my_xor u_x1 (.a(a_sr[0]), .b(b_sr[0]), .y(p));
    my_xor u_x2 (.a(p),       .b(c),       .y(s));
    my_and u_a1 (.a(a_sr[0]), .b(b_sr[0]), .y(g));
    my_and u_a2 (.a(p),       .b(c),       .y(pc));
    my_or  u_o1 (.a(g),       .b(pc),      .y(co));

    assign s_unused = 1'b0;
    assign s_nxt    = {s, s_sr};
    assign last     = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            s_sr <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        c    <= cin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    s_sr <= s_nxt[WIDTH-1:1];
                    c    <= co;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        sum  <= s_nxt;
                        cout <= co;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // c is the carry into the MSB on the last slice pass.
    logic ovf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       ovf_q <= 1'b0;
        else if (state_q == RUN && last) ovf_q <= c ^ co;
    end
    assign ovf = ovf_q;
`else
    assign ovf = s_unused;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Randomized self-checking bench for serial_add_seq (WIDTH=8).
// Expected results come from integer addition and signed-range rules.

module tb_serial_add_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int n_chk  = 0;
    int n_pass = 0;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #25 clk = ~clk;

    function automatic logic [W:0] ref_add(
        input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        int unsigned t;
        t = int'(x) + int'(y) + int'(ci);
        return t[W:0];
    endfunction

    function automatic logic ref_ovf(
        input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
`ifdef SERIAL_ADD_OVF_EN
        int sx, sy, st;
        sx = (x >= 8'h80) ? int'(x) - 256 : int'(x);
        sy = (y >= 8'h80) ? int'(y) - 256 : int'(y);
        st = sx + sy + int'(ci);
        return (st > 127) || (st < -128);
`else
        return 1'b0;
`endif
    endfunction

    // Issues one add and watches W+1 edges after acceptance.
    task automatic add_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input bit hold,
                          output int lat, output int ndone);
        @(negedge clk);
        a = x; b = y; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = -1; ndone = 0;
        for (int k = 1; k <= W + 1; k++) begin
            @(posedge clk); #1;
            if (hold) begin
                a = W'($urandom); b = W'($urandom);
            end
            if (done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
        end
        start = 1'b0;
    endtask

    task automatic chk_res(input string nm, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic ci);
        logic [W:0] e;
        e = ref_add(x, y, ci);
        n_chk++;
        if (sum !== e[W-1:0])
            $display("FAIL %s sum got %h want %h", nm, sum, e[W-1:0]);
        else n_pass++;
        n_chk++;
        if (cout !== e[W])
            $display("FAIL %s cout got %b want %b", nm, cout, e[W]);
        else n_pass++;
        n_chk++;
        if (ovf !== ref_ovf(x, y, ci))
            $display("FAIL %s ovf got %b want %b", nm, ovf, ref_ovf(x, y, ci));
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({busy, done, cout, ovf} !== 4'b0)
            $display("FAIL reset flags got %b want 0000", {busy, done, cout, ovf});
        else n_pass++;
        n_chk++;
        if (sum !== '0) $display("FAIL reset sum got %h want 00", sum);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [W-1:0] va [3] = '{8'h5A, 8'hFF, 8'h7F};
        logic [W-1:0] vb [3] = '{8'h33, 8'h01, 8'h00};
        logic         vc [3] = '{1'b0, 1'b0, 1'b1};
        int lat, nd;
        for (int i = 0; i < 3; i++) begin
            add_op(va[i], vb[i], vc[i], 1'b0, lat, nd);
            chk_res("directed", va[i], vb[i], vc[i]);
            n_chk++;
            if (lat != W) $display("FAIL latency got %0d want %0d", lat, W);
            else n_pass++;
            n_chk++;
            if (nd != 1) $display("FAIL done_count got %0d want 1", nd);
            else n_pass++;
            n_chk++;
            if (busy !== 1'b0) $display("FAIL busy_end got %b want 0", busy);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [W-1:0] x, y;
        logic ci;
        int lat, nd;
        for (int i = 0; i < 20; i++) begin
            x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
            add_op(x, y, ci, 1'b0, lat, nd);
            chk_res("random", x, y, ci);
        end
    endtask

    task automatic test_ignore_start;
        int lat, nd;
        add_op(8'hC4, 8'h5D, 1'b1, 1'b1, lat, nd);
        chk_res("ignore", 8'hC4, 8'h5D, 1'b1);
        n_chk++;
        if (nd != 1) $display("FAIL ignore_done got %0d want 1", nd);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int lat, nd;
        @(negedge clk);
        a = 8'hAB; b = 8'h11; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_chk++;
        if ({busy, done, cout, ovf} !== 4'b0)
            $display("FAIL midrst flags got %b want 0000", {busy, done, cout, ovf});
        else n_pass++;
        n_chk++;
        if (sum !== '0) $display("FAIL midrst sum got %h want 00", sum);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_chk++;
        if (nd != 0) $display("FAIL midrst_done got %0d want 0", nd);
        else n_pass++;
        add_op(8'h10, 8'h20, 1'b0, 1'b0, lat, nd);
        chk_res("after_rst", 8'h10, 8'h20, 1'b0);
    endtask

    task automatic test_back_to_back;
        int pos[$];
        @(negedge clk);
        a = 8'h9C; b = 8'h71; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done) pos.push_back(k);
            if (k == W + 1) begin
                n_chk++;
                if (busy !== 1'b0) $display("FAIL b2b_idle got %b want 0", busy);
                else n_pass++;
            end
            if (k == W + 2) begin
                n_chk++;
                if (busy !== 1'b1) $display("FAIL b2b_accept got %b want 1", busy);
                else n_pass++;
            end
        end
        start = 1'b0;
        n_chk++;
        if (pos.size() != 3)
            $display("FAIL b2b_count got %0d want 3", pos.size());
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (i >= pos.size() || pos[i] != W + 10 * i)
                $display("FAIL b2b_pos%0d got %0d want %0d", i,
                         (i < pos.size()) ? pos[i] : -1, W + 10 * i);
            else n_pass++;
        end
        chk_res("b2b", 8'h9C, 8'h71, 1'b1);
        repeat (W + 4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
